// File: rtl/pulse_stretcher_pkg.sv
// Shared types and constants for the pulse stretcher and its tick prescaler.
package pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/pulse_stretcher_tick_gen.sv
// Prescaler: one-cycle tick every DIV clocks, with a synchronous clear so
// callers can realign the tick phase to the start of an interval.
module tick_gen
    import pulse_stretcher_pkg::*;
#(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = clog2(DIV);
    localparam logic [CNT_W-1:0] TC = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr || count == TC) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == TC);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle trigger strobes into fixed-width pulses with an
// enforced low gap, queueing triggers that arrive while busy.
// Optional PULSE_TOTAL_EN adds a 16-bit wrapping count of pulses started.
//
// state | meaning
// IDLE  | no pulse in progress, waiting for trig or a queued request
// HIGH  | out asserted for ON_TICKS ticks
// GAP   | out low for OFF_TICKS ticks before the next pulse may start
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int DIV       = 50000,
    parameter int ON_TICKS  = 10,
    parameter int OFF_TICKS = 5,
    parameter int PEND_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trig,
    output logic              out,
    output logic              busy,
    output logic [PEND_W-1:0] pend_cnt,
    output logic              overflow
`ifdef PULSE_TOTAL_EN
    ,
    output logic [15:0]       pulse_total
`endif
);

    localparam int TICK_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int TICK_W   = clog2(TICK_MAX + 1);
    localparam logic [TICK_W-1:0] ON_LOAD  = TICK_W'(ON_TICKS);
    localparam logic [TICK_W-1:0] OFF_LOAD = TICK_W'(OFF_TICKS);
    localparam logic [TICK_W-1:0] TICK_ONE = TICK_W'(1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    state_t             state;
    state_t             state_next;
    logic [TICK_W-1:0]  tick_cnt;
    logic               tick;
    logic               last_tick;
    logic               state_enter;
    logic               pend_any;
    logic               queue_req;
    logic               dequeue;
    logic               out_next;

    assign last_tick   = tick && (tick_cnt == TICK_ONE);
    assign pend_any    = (pend_cnt != '0);
    assign state_enter = (state_next != state);

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_enter),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (trig || pend_any) state_next = HIGH;
            end
            HIGH: begin
                if (last_tick) state_next = GAP;
            end
            GAP: begin
                if (last_tick) state_next = pend_any ? HIGH : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        out_next = (state_next == HIGH);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out <= 1'b0;
        end else begin
            out <= out_next;
        end
    end

    // Down-counter reloaded on every state entry; the interval ends on the tick
    // that finds it at one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (state_enter) begin
            case (state_next)
                HIGH:    tick_cnt <= ON_LOAD;
                GAP:     tick_cnt <= OFF_LOAD;
                default: tick_cnt <= '0;
            endcase
        end else if (tick && tick_cnt != '0) begin
            tick_cnt <= tick_cnt - 1'b1;
        end
    end

    // A trigger in IDLE with an empty queue starts a pulse directly; anything
    // else is queued. A simultaneous queue and dequeue leaves the count alone.
    assign queue_req = trig && !(state == IDLE && !pend_any);
    assign dequeue   = pend_any && ((state == IDLE) || (state == GAP && last_tick));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_cnt <= '0;
            overflow <= 1'b0;
        end else if (queue_req && !dequeue) begin
            if (pend_cnt == PEND_MAX) begin
                overflow <= 1'b1;
            end else begin
                pend_cnt <= pend_cnt + 1'b1;
            end
        end else if (!queue_req && dequeue) begin
            pend_cnt <= pend_cnt - 1'b1;
        end
    end

`ifdef PULSE_TOTAL_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pulse_total <= '0;
        end else if (state_enter && state_next == HIGH) begin
            pulse_total <= pulse_total + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher with DIV=4, ON_TICKS=3, OFF_TICKS=2, PEND_W=2.
module tb_pulse_stretcher;

    localparam int DIV       = 4;
    localparam int ON_TICKS  = 3;
    localparam int OFF_TICKS = 2;
    localparam int PEND_W    = 2;
    localparam int NREC      = 256;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              trig = 1'b0;
    logic              out;
    logic              busy;
    logic [PEND_W-1:0] pend_cnt;
    logic              overflow;
`ifdef PULSE_TOTAL_EN
    logic [15:0]       pulse_total;
`endif

    pulse_stretcher #(
        .DIV       (DIV),
        .ON_TICKS  (ON_TICKS),
        .OFF_TICKS (OFF_TICKS),
        .PEND_W    (PEND_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .trig        (trig),
        .out         (out),
        .busy        (busy),
        .pend_cnt    (pend_cnt),
        .overflow    (overflow)
`ifdef PULSE_TOTAL_EN
        ,
        .pulse_total (pulse_total)
`endif
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc;
    bit   trig_at [NREC];
    logic out_h   [NREC];
    logic busy_h  [NREC];
    logic ovf_h   [NREC];
    int   pend_h  [NREC];

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sample();
        out_h[cyc]  = out;
        busy_h[cyc] = busy;
        pend_h[cyc] = int'(pend_cnt);
        ovf_h[cyc]  = overflow;
    endtask

    task automatic clear_sched();
        for (int i = 0; i < NREC; i++) trig_at[i] = 1'b0;
    endtask

    // Index c holds the outputs seen after edge c-1; trig_at[e] is sampled at edge e.
    task automatic reset_dut();
        trig = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        cyc = 0;
        clear_sched();
        sample();
    endtask

    task automatic run_to(input int last);
        while (cyc < last) begin
            trig = trig_at[cyc];
            @(posedge clk);
            #1;
            cyc++;
            sample();
        end
        trig = 1'b0;
    endtask

    function automatic int count_pulses(input int from, input int to);
        int n;
        n = 0;
        for (int c = from + 1; c <= to; c++)
            if (out_h[c] === 1'b1 && out_h[c-1] === 1'b0) n++;
        return n;
    endfunction

    // Length of complete runs of 'level' bounded by the opposite level.
    function automatic int run_len(input logic level, input int from, input int to,
                                   input bit want_max);
        int  best;
        int  len;
        bit  started;
        best    = want_max ? 0 : 9999;
        len     = 0;
        started = 1'b0;
        for (int c = from; c <= to; c++) begin
            if (out_h[c] === level) begin
                if (started) len++;
            end else begin
                if (started && len > 0)
                    best = want_max ? ((len > best) ? len : best)
                                    : ((len < best) ? len : best);
                started = 1'b1;
                len     = 0;
            end
        end
        return best;
    endfunction

    initial begin
        #12;
        chk("rst_out",      int'(out),      0);
        chk("rst_busy",     int'(busy),     0);
        chk("rst_pend",     int'(pend_cnt), 0);
        chk("rst_overflow", int'(overflow), 0);

        // single trigger
        reset_dut();
        trig_at[10] = 1'b1;
        run_to(40);
        chk("t1_out_c10",  int'(out_h[10]),  0);
        chk("t1_out_c11",  int'(out_h[11]),  1);
        chk("t1_out_c22",  int'(out_h[22]),  1);
        chk("t1_out_c23",  int'(out_h[23]),  0);
        chk("t1_pulses",   count_pulses(0, 40), 1);
        chk("t1_busy_c11", int'(busy_h[11]), 1);
        chk("t1_busy_c30", int'(busy_h[30]), 1);
        chk("t1_busy_c31", int'(busy_h[31]), 0);
        chk("t1_overflow", int'(ovf_h[40]),  0);

        // one queued trigger
        reset_dut();
        trig_at[10] = 1'b1;
        trig_at[15] = 1'b1;
        run_to(60);
        chk("t2_pend_c15", pend_h[15], 0);
        chk("t2_pend_c16", pend_h[16], 1);
        chk("t2_pend_c30", pend_h[30], 1);
        chk("t2_pend_c31", pend_h[31], 0);
        chk("t2_out_c30",  int'(out_h[30]), 0);
        chk("t2_out_c31",  int'(out_h[31]), 1);
        chk("t2_out_c42",  int'(out_h[42]), 1);
        chk("t2_out_c43",  int'(out_h[43]), 0);
        chk("t2_busy_c50", int'(busy_h[50]), 1);
        chk("t2_busy_c51", int'(busy_h[51]), 0);
        chk("t2_pulses",   count_pulses(0, 60), 2);

        // queue saturation and overflow
        reset_dut();
        trig_at[10] = 1'b1;
        trig_at[12] = 1'b1;
        trig_at[14] = 1'b1;
        trig_at[16] = 1'b1;
        trig_at[18] = 1'b1;
        run_to(120);
        chk("t3_pend_c13", pend_h[13], 1);
        chk("t3_pend_c17", pend_h[17], 3);
        chk("t3_pend_c19", pend_h[19], 3);
        chk("t3_ovf_c18",  int'(ovf_h[18]), 0);
        chk("t3_ovf_c19",  int'(ovf_h[19]), 1);
        chk("t3_pulses",   count_pulses(0, 120), 4);
        chk("t3_width_min", run_len(1'b1, 0, 120, 1'b0), 12);
        chk("t3_width_max", run_len(1'b1, 0, 120, 1'b1), 12);
        chk("t3_gap_min",   run_len(1'b0, 11, 120, 1'b0), 8);
        chk("t3_gap_max",   run_len(1'b0, 11, 120, 1'b1), 8);
        chk("t3_out_c71",  int'(out_h[71]), 1);
        chk("t3_out_c83",  int'(out_h[83]), 0);
        chk("t3_ovf_sticky", int'(ovf_h[120]), 1);

        // trigger on the GAP->HIGH dequeue edge
        reset_dut();
        trig_at[10] = 1'b1;
        trig_at[15] = 1'b1;
        trig_at[30] = 1'b1;
        run_to(90);
        chk("t4_pend_c30", pend_h[30], 1);
        chk("t4_pend_c31", pend_h[31], 1);
        chk("t4_pend_c51", pend_h[51], 0);
        chk("t4_out_c51",  int'(out_h[51]), 1);
        chk("t4_pulses",   count_pulses(0, 90), 3);
`ifdef PULSE_TOTAL_EN
        chk("t4_pulse_total", int'(pulse_total), 3);
`endif

        // asynchronous reset mid-pulse with a non-empty queue
        reset_dut();
        trig_at[10] = 1'b1;
        trig_at[12] = 1'b1;
        trig_at[14] = 1'b1;
        trig_at[16] = 1'b1;
        trig_at[18] = 1'b1;
        run_to(35);
        chk("t5_pre_out",  int'(out_h[35]),  1);
        chk("t5_pre_pend", pend_h[35],       2);
        chk("t5_pre_ovf",  int'(ovf_h[35]),  1);
        #2 rst = 1'b0;
        #1;
        chk("t5_rst_out",  int'(out),      0);
        chk("t5_rst_busy", int'(busy),     0);
        chk("t5_rst_pend", int'(pend_cnt), 0);
        chk("t5_rst_ovf",  int'(overflow), 0);
        #1 rst = 1'b1;
        cyc = 0;
        clear_sched();
        sample();
        run_to(60);
        chk("t5_post_pulses", count_pulses(0, 60), 0);
        chk("t5_post_busy",   int'(busy_h[60]), 0);
        chk("t5_post_pend",   pend_h[60], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
